// File: rtl/arm_cache_pkg.sv
// Shared definitions for the data cache: geometry defaults, address field positions, FSM states.
package arm_cache_pkg;

  localparam int unsigned DEF_SETS  = 64;
  localparam int unsigned DEF_TAG_W = 10;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_SETS);

  // Address layout: [tag | index | word select | byte offset]
  localparam int unsigned WSEL_BIT  = 2;
  localparam int unsigned IDX_LSB   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WRITE = 2'd3
  } state_t;

  // The SRAM controller addresses 16-bit halfwords.
  function automatic logic [31:0] sram_haddr(input logic [31:0] byte_addr);
    return byte_addr >> 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag, valid and 2-word line arrays.
// Reads are combinational; writes (full-line fill or single-word update) are synchronous.
module cache_way
  import arm_cache_pkg::*;
#(
  parameter int unsigned SETS  = DEF_SETS,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [63:0]      rd_line,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_line,
  input  logic             word_en,
  input  logic             word_sel,
  input  logic [31:0]      word_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      w0_q  [SETS];
  logic [31:0]      w1_q  [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = {w1_q[idx], w0_q[idx]};

  // Valid bits: cleared by reset, set when a line is installed.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (fill_en) valid_q[idx] <= 1'b1;
  end

  // Tag/data storage: full line on fill, single word on a write hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx] <= fill_tag;
      w0_q[idx]  <= fill_line[31:0];
      w1_q[idx]  <= fill_line[63:32];
    end else if (word_en) begin
      if (word_sel) w1_q[idx] <= word_data;
      else          w0_q[idx] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache controller.
module data_cache_ctrl
  import arm_cache_pkg::*;
#(
  parameter int unsigned SETS  = DEF_SETS,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  state_t           state_q, state_d;
  logic [31:2]      addr_q;
  logic [31:0]      wdata_q, word0_q;
  logic [SETS-1:0]  lru_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, tag0, tag1;
  logic             wsel, v0, v1, hit0, hit1, hit, hit_way, victim;
  logic [63:0]      line0, line1, hit_line;
  logic [31:0]      hit_word;
  logic             fill_en, word_en, lru_we, lru_val, latch_req, latch_w0;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Lookup uses the live request in IDLE and the latched request while a transaction is open.
  assign idx  = (state_q == IDLE) ? addr[IDX_LSB +: IDX_W]   : addr_q[IDX_LSB +: IDX_W];
  assign tag  = (state_q == IDLE) ? addr[TAG_LSB +: TAG_W]   : addr_q[TAG_LSB +: TAG_W];
  assign wsel = (state_q == IDLE) ? addr[WSEL_BIT]           : addr_q[WSEL_BIT];

  assign hit0     = v0 && (tag0 == tag);
  assign hit1     = v1 && (tag1 == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0 && hit1;
  assign hit_line = hit_way ? line1 : line0;
  assign hit_word = wsel ? hit_line[63:32] : hit_line[31:0];
  assign victim   = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[idx]);

  cache_way #(.SETS(SETS), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_way0 (
    .clk(clk), .rst(rst), .idx(idx),
    .rd_valid(v0), .rd_tag(tag0), .rd_line(line0),
    .fill_en(fill_en && !victim), .fill_tag(tag), .fill_line({sram_rdata, word0_q}),
    .word_en(word_en && !hit_way), .word_sel(wsel), .word_data(wdata_q)
  );

  cache_way #(.SETS(SETS), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_way1 (
    .clk(clk), .rst(rst), .idx(idx),
    .rd_valid(v1), .rd_tag(tag1), .rd_line(line1),
    .fill_en(fill_en && victim), .fill_tag(tag), .fill_line({sram_rdata, word0_q}),
    .word_en(word_en && hit_way), .word_sel(wsel), .word_data(wdata_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch and first fill word buffer.
  always_ff @(posedge clk) begin
    if (latch_req) begin
      addr_q  <= addr[31:2];
      wdata_q <= wdata;
    end
    if (latch_w0) word0_q <= sram_rdata;
  end

  // LRU bits: each names the least-recently-used way of its set.
  always_ff @(posedge clk) begin
    if (rst)         lru_q <= '0;
    else if (lru_we) lru_q[idx] <= lru_val;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b1;
    rdata      = '0;
    sram_r_en  = 1'b0;
    sram_w_en  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    latch_req  = 1'b0;
    latch_w0   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          ready     = 1'b0;
          latch_req = 1'b1;
          state_d   = WRITE;
        end else if (mem_r_en) begin
          if (hit) begin
            rdata   = hit_word;
            lru_we  = 1'b1;
            lru_val = !hit_way;
          end else begin
            ready     = 1'b0;
            latch_req = 1'b1;
            state_d   = FILL0;
          end
        end
      end
      FILL0: begin
        ready     = 1'b0;
        sram_r_en = 1'b1;
        sram_addr = sram_haddr({addr_q[31:3], 3'b000});
        if (sram_ready) begin
          latch_w0 = 1'b1;
          state_d  = FILL1;
        end
      end
      FILL1: begin
        ready     = 1'b0;
        sram_r_en = 1'b1;
        sram_addr = sram_haddr({addr_q[31:3], 3'b100});
        if (sram_ready) begin
          fill_en = 1'b1;
          lru_we  = 1'b1;
          lru_val = !victim;
          state_d = IDLE;
        end
      end
      WRITE: begin
        ready      = sram_ready;
        sram_w_en  = 1'b1;
        sram_addr  = sram_haddr({addr_q[31:2], 2'b00});
        sram_wdata = wdata_q;
        if (sram_ready) begin
          word_en = hit;
          lru_we  = hit;
          lru_val = !hit_way;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed testbench for data_cache_ctrl with a small latency-2 SRAM controller model.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_r_en, sram_w_en, sram_ready;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_cache_ctrl #(.SETS(64), .TAG_W(10)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // SRAM model: halfword-addressed storage, unwritten locations return 0xA000_0000 | haddr.
  logic [31:0] mem [logic [31:0]];
  int unsigned mem_gen = 0;
  int unsigned lat_cnt = 0;
  int unsigned n_proto = 0;
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];
  logic        p_pend = 1'b0, p_r = 1'b0, p_w = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | a;
  endfunction

  always @(sram_addr or mem_gen) sram_rdata = mem_rd(sram_addr);

  always_comb sram_ready = !(sram_r_en || sram_w_en) || (lat_cnt == 2);

  always @(posedge clk) begin
    if (sram_r_en && sram_w_en) n_proto++;
    if (p_pend && (sram_r_en != p_r || sram_w_en != p_w || sram_addr != p_addr ||
                   (sram_w_en && sram_wdata != p_wd))) n_proto++;
    if ((sram_r_en || sram_w_en) && sram_ready) begin
      if (sram_w_en) begin
        wr_log.push_back(sram_addr);
        mem[sram_addr] = sram_wdata;
        mem_gen++;
      end else begin
        rd_log.push_back(sram_addr);
      end
    end
    p_pend = !rst && (sram_r_en || sram_w_en) && !sram_ready;
    p_r    = sram_r_en;
    p_w    = sram_w_en;
    p_addr = sram_addr;
    p_wd   = sram_wdata;
    if (rst || !(sram_r_en || sram_w_en) || sram_ready) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and hold it until ready; waits = negedges spent stalled.
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] d, output int waits);
    @(negedge clk);
    mem_r_en = r; mem_w_en = w; addr = a; wdata = wd; waits = 0;
    #1;
    while (!ready && waits < 100) begin
      @(negedge clk);
      waits++;
      #1;
    end
    d = rdata;
    @(posedge clk);
    #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int w;
    mem[32'h80] = 32'h1111_1111;
    mem[32'h82] = 32'h2222_2222;

    // Reset state
    do_reset();
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sram_en", {30'd0, sram_r_en, sram_w_en}, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    // Cold miss then same-line hit
    rd_log.delete(); wr_log.delete();
    req(1'b1, 1'b0, 32'h100, '0, d, w);
    check("t1_miss_wait", 32'(w), 32'd7);
    check("t1_miss_rdata", d, 32'h1111_1111);
    check("t1_nreads", 32'(rd_log.size()), 32'd2);
    check("t1_rd0_addr", rd_log[0], 32'h80);
    check("t1_rd1_addr", rd_log[1], 32'h82);
    req(1'b1, 1'b0, 32'h104, '0, d, w);
    check("t1_hit_wait", 32'(w), 32'd0);
    check("t1_hit_rdata", d, 32'h2222_2222);
    check("t1_hit_nreads", 32'(rd_log.size()), 32'd2);

    // Write hit goes through and updates the line
    rd_log.delete(); wr_log.delete();
    req(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, d, w);
    check("t3_wr_wait", 32'(w), 32'd3);
    check("t3_nwrites", 32'(wr_log.size()), 32'd1);
    check("t3_wr_addr", wr_log[0], 32'h82);
    req(1'b1, 1'b0, 32'h104, '0, d, w);
    check("t3_rd_wait", 32'(w), 32'd0);
    check("t3_rd_rdata", d, 32'hDEAD_BEEF);

    // Write miss: no allocate
    rd_log.delete(); wr_log.delete();
    req(1'b0, 1'b1, 32'h900, 32'h5A5A_5A5A, d, w);
    check("t4_nwrites", 32'(wr_log.size()), 32'd1);
    check("t4_nreads_w", 32'(rd_log.size()), 32'd0);
    req(1'b1, 1'b0, 32'h900, '0, d, w);
    check("t4_rd_wait", 32'(w), 32'd7);
    check("t4_nreads", 32'(rd_log.size()), 32'd2);
    check("t4_rd0_addr", rd_log[0], 32'h480);
    check("t4_rd_rdata", d, 32'h5A5A_5A5A);

    // LRU replacement in set 0x20
    do_reset();
    req(1'b1, 1'b0, 32'h100, '0, d, w);
    check("t2_a_miss", 32'(w), 32'd7);
    req(1'b1, 1'b0, 32'h300, '0, d, w);
    check("t2_b_miss", 32'(w), 32'd7);
    check("t2_b_rdata", d, 32'hA000_0180);
    req(1'b1, 1'b0, 32'h100, '0, d, w);
    check("t2_a_hit", 32'(w), 32'd0);
    check("t2_a_rdata", d, 32'h1111_1111);
    req(1'b1, 1'b0, 32'h500, '0, d, w);
    check("t2_c_miss", 32'(w), 32'd7);
    check("t2_c_rdata", d, 32'hA000_0280);
    req(1'b1, 1'b0, 32'h100, '0, d, w);
    check("t2_a_hit2", 32'(w), 32'd0);
    req(1'b1, 1'b0, 32'h300, '0, d, w);
    check("t2_b_refill", 32'(w), 32'd7);
    req(1'b1, 1'b0, 32'h500, '0, d, w);
    check("t2_c_evicted", 32'(w), 32'd7);

    // Reset during FILL1
    @(negedge clk);
    mem_r_en = 1'b1; addr = 32'h200;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(sram_r_en && sram_addr == 32'h102) && w < 50);
    check("t5_reach_fill1", 32'(w < 50), 32'd1);
    rst = 1'b1; mem_r_en = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_r_en", 32'(sram_r_en), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    req(1'b1, 1'b0, 32'h100, '0, d, w);
    check("t5_reread_miss", 32'(w), 32'd7);

    // Idle cycles, then simultaneous read+write treated as a write
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("t6_idle", {29'd0, ready, sram_r_en, sram_w_en}, 32'd4);
    end
    rd_log.delete(); wr_log.delete();
    req(1'b1, 1'b1, 32'h104, 32'h1234_5678, d, w);
    check("t6_rw_wait", 32'(w), 32'd3);
    check("t6_rw_nwrites", 32'(wr_log.size()), 32'd1);
    check("t6_rw_nreads", 32'(rd_log.size()), 32'd0);
    req(1'b1, 1'b0, 32'h104, '0, d, w);
    check("t6_rd_rdata", d, 32'h1234_5678);

    check("sram_protocol", 32'(n_proto), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
